reg_mmcm_drp_multi: RTL and testbench

Register-mapped DRP master for up to 8 MMCM/PLL instances, driven by the USB register bus.
- Adds a proper DRP handshake over the fixed-pulse scheme: waits for drdy, captures read data, times out, and reports busy and error status.
- Channel-select register routes each access to one primitive; per-channel DRP reset bits.
- Sits in the clock-control register block, between the USB register decoder and the MMCM primitives.

---
 rtl/mmcm_drp_pkg.sv | 16 +
 rtl/reg_mmcm_drp_multi_if.sv | 12 +
 rtl/mmcm_drp_engine.sv | 81 ++++++++
 rtl/reg_mmcm_drp_multi.sv | 107 ++++++++++
 tb/tb_reg_mmcm_drp_multi.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared constants, register map defaults and FSM states for the MMCM DRP master
package mmcm_drp_pkg;
  localparam int DRP_DW = 16;
  localparam int DRP_AW = 7;
  localparam int ADDR_DRP_ADDR = 0;
  localparam int ADDR_DRP_DATA = 1;
  localparam int ADDR_DRP_RESET = 2;
  localparam int ADDR_DRP_SEL = 3;
  localparam int ADDR_DRP_STATUS = 4;
  localparam int ADDR_DRP_MASK = 5;
  localparam int ST_BUSY = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_BADSEL = 3;
  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RMW_WR} drp_state_t;
endpackage

// File: rtl/reg_mmcm_drp_multi_if.sv
// reg_mmcm_drp_multi_if: USB register bus between the register decoder (master) and a register block (slave)
interface reg_mmcm_drp_multi_if #(parameter int pBYTECNT_SIZE = 7);
  logic selected;
  logic [7:0] reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0] reg_datai;
  logic [7:0] reg_datao;
  logic reg_read;
  logic reg_write;
  modport master(output selected, reg_address, reg_bytecnt, reg_datai, reg_read, reg_write, input reg_datao);
  modport slave(input selected, reg_address, reg_bytecnt, reg_datai, reg_read, reg_write, output reg_datao);
endinterface

// File: rtl/mmcm_drp_engine.sv
// mmcm_drp_engine: DRP transaction FSM with drdy wait, timeout, one-cycle den/dwe pulses and read-data capture
module mmcm_drp_engine
  import mmcm_drp_pkg::*;
#(
  parameter int pCHANNELS = 2,
  parameter int pTIMEOUT = 255
) (
  input  logic                        clk_usb,
  input  logic                        reset_i,
  input  logic                        launch,
  input  logic                        we,
  input  logic                        rmw,
  input  logic [2:0]                  sel,
  input  logic [DRP_DW-1:0]           wdata,
  input  logic [DRP_DW-1:0]           mask,
  input  logic [DRP_DW*pCHANNELS-1:0] drp_dout,
  input  logic [pCHANNELS-1:0]        drp_drdy,
  output logic                        busy,
  output logic                        timeout,
  output logic [pCHANNELS-1:0]        drp_den,
  output logic                        drp_dwe,
  output logic [DRP_DW-1:0]           drp_din,
  output logic [DRP_DW-1:0]           rdata
);
  drp_state_t state_q, state_d;
  logic [15:0] cnt_q;
  logic [2:0] sel_q;
  logic we_q, rmw_q, drdy_sel, expire;
  logic [DRP_DW-1:0] mask_q, dout_sel;
  logic [pCHANNELS-1:0] onehot;
  assign onehot = pCHANNELS'(1) << sel_q;
  assign drdy_sel = |(drp_drdy & onehot);
  assign expire = cnt_q == 16'(pTIMEOUT - 1);
  // read-data mux for the channel latched at launch
  always_comb begin
    dout_sel = '0;
    for (int c = 0; c < pCHANNELS; c++) dout_sel = (sel_q == 3'(c)) ? drp_dout[DRP_DW*c +: DRP_DW] : dout_sel;
  end
  // state register; async reset kills any access in flight
  always_ff @(posedge clk_usb or posedge reset_i)
    if (reset_i) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state: drdy beats a same-cycle timeout expiry
  always_comb begin
    state_d = state_q == S_IDLE ? (launch ? S_STROBE : S_IDLE) :
              state_q == S_WAIT ? (drdy_sel ? (rmw_q ? S_RMW_WR : S_IDLE) : (expire ? S_IDLE : S_WAIT)) :
              S_WAIT;
  end
  // transaction context, wait counter and data capture
  always_ff @(posedge clk_usb or posedge reset_i)
    if (reset_i) begin
      cnt_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      rmw_q <= 1'b0;
      mask_q <= '1;
      drp_din <= '0;
      rdata <= '0;
    end else begin
      cnt_q <= state_q == S_WAIT ? cnt_q + 16'd1 : 16'd0;
      if (state_q == S_IDLE && launch) begin
        sel_q <= sel;
        we_q <= we;
        rmw_q <= rmw;
        mask_q <= mask;
        drp_din <= wdata;
      end
      if (state_q == S_WAIT && drdy_sel) begin
        rdata <= dout_sel;
        if (rmw_q) drp_din <= (dout_sel & ~mask_q) | (drp_din & mask_q);
        rmw_q <= 1'b0;
      end
    end
  // outputs decoded from state so den/dwe fall with the async reset
  always_comb begin
    drp_den = (state_q == S_STROBE || state_q == S_RMW_WR) ? onehot : '0;
    drp_dwe = state_q == S_RMW_WR || (state_q == S_STROBE && we_q && !rmw_q);
    busy = state_q != S_IDLE;
    timeout = state_q == S_WAIT && !drdy_sel && expire;
  end
endmodule

// File: rtl/reg_mmcm_drp_multi.sv
// reg_mmcm_drp_multi: register-mapped DRP master for up to 8 MMCM/PLL ports; DRP_RMW_EN adds a masked read-modify-write path
module reg_mmcm_drp_multi
  import mmcm_drp_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pCHANNELS = 2,
  parameter int pTIMEOUT = 255,
  parameter int pDRP_ADDR = ADDR_DRP_ADDR,
  parameter int pDRP_DATA = ADDR_DRP_DATA,
  parameter int pDRP_RESET = ADDR_DRP_RESET,
  parameter int pDRP_SEL = ADDR_DRP_SEL,
  parameter int pDRP_STATUS = ADDR_DRP_STATUS
) (
  input  logic                        clk_usb,
  input  logic                        reset_i,
  reg_mmcm_drp_multi_if.slave         bus,
  output logic [DRP_AW-1:0]           drp_addr,
  output logic [DRP_DW-1:0]           drp_din,
  output logic                        drp_dwe,
  output logic [pCHANNELS-1:0]        drp_den,
  input  logic [DRP_DW*pCHANNELS-1:0] drp_dout,
  input  logic [pCHANNELS-1:0]        drp_drdy,
  output logic [pCHANNELS-1:0]        drp_reset
);
  logic wr, rd, wr_addr, wr_data, wr_sel, wr_reset, wr_status, busy, timeout, sel_bad, launch, rmw;
  logic b0, b1;
  logic timeout_f, overrun_f, badsel_f;
  logic [2:0] sel_q;
  logic [DRP_DW-1:0] wdata_q, rdata, mask;
  logic [7:0] mask_rd;
  assign wr = bus.selected && bus.reg_write;
  assign rd = bus.selected && bus.reg_read;
  assign b0 = bus.reg_bytecnt == pBYTECNT_SIZE'(0);
  assign b1 = bus.reg_bytecnt == pBYTECNT_SIZE'(1);
  assign wr_addr = wr && bus.reg_address == 8'(pDRP_ADDR);
  assign wr_data = wr && bus.reg_address == 8'(pDRP_DATA);
  assign wr_sel = wr && bus.reg_address == 8'(pDRP_SEL);
  assign wr_reset = wr && bus.reg_address == 8'(pDRP_RESET);
  assign wr_status = wr && bus.reg_address == 8'(pDRP_STATUS);
  assign sel_bad = int'(sel_q) >= pCHANNELS;
  assign launch = wr_addr && !busy && !sel_bad;
`ifdef DRP_RMW_EN
  logic [DRP_DW-1:0] mask_q;
  logic wr_mask;
  assign wr_mask = wr && bus.reg_address == 8'(ADDR_DRP_MASK);
  assign mask = mask_q;
  assign rmw = bus.reg_datai[7] && mask_q != 16'hFFFF;
  assign mask_rd = bus.reg_address != 8'(ADDR_DRP_MASK) ? 8'h00 : b0 ? mask_q[7:0] : b1 ? mask_q[15:8] : 8'h00;
  // bit mask of the fields a write launch may change
  always_ff @(posedge clk_usb or posedge reset_i)
    if (reset_i) mask_q <= 16'hFFFF;
    else if (wr_mask && b0) mask_q[7:0] <= bus.reg_datai;
    else if (wr_mask && b1) mask_q[15:8] <= bus.reg_datai;
`else
  assign mask = 16'hFFFF;
  assign rmw = 1'b0;
  assign mask_rd = 8'h00;
`endif
  // register file; ADDR/DATA are frozen while a transaction is in flight
  always_ff @(posedge clk_usb or posedge reset_i)
    if (reset_i) begin
      wdata_q <= '0;
      sel_q <= '0;
      drp_addr <= '0;
      drp_reset <= '0;
      timeout_f <= 1'b0;
      overrun_f <= 1'b0;
      badsel_f <= 1'b0;
    end else begin
      if (wr_data && !busy && b0) wdata_q[7:0] <= bus.reg_datai;
      if (wr_data && !busy && b1) wdata_q[15:8] <= bus.reg_datai;
      if (wr_addr && !busy) drp_addr <= bus.reg_datai[DRP_AW-1:0];
      if (wr_sel) sel_q <= bus.reg_datai[2:0];
      if (wr_reset) drp_reset <= bus.reg_datai[pCHANNELS-1:0];
      timeout_f <= timeout || (timeout_f && !wr_status);
      overrun_f <= ((wr_addr || wr_data) && busy) || (overrun_f && !wr_status);
      badsel_f <= (wr_addr && !busy && sel_bad) || (badsel_f && !wr_status);
    end
  // combinational read-back, zero unless this block is being read
  always_comb begin
    bus.reg_datao = !rd ? 8'h00 :
                    bus.reg_address == 8'(pDRP_ADDR) ? {busy, drp_addr} :
                    bus.reg_address == 8'(pDRP_DATA) ? (b0 ? rdata[7:0] : b1 ? rdata[15:8] : 8'h00) :
                    bus.reg_address == 8'(pDRP_RESET) ? 8'(drp_reset) :
                    bus.reg_address == 8'(pDRP_SEL) ? {5'b0, sel_q} :
                    bus.reg_address == 8'(pDRP_STATUS) ? {4'b0, badsel_f, overrun_f, timeout_f, busy} :
                    mask_rd;
  end
  mmcm_drp_engine #(.pCHANNELS(pCHANNELS), .pTIMEOUT(pTIMEOUT)) u_engine (
    .clk_usb (clk_usb),
    .reset_i (reset_i),
    .launch  (launch),
    .we      (bus.reg_datai[7]),
    .rmw     (rmw),
    .sel     (sel_q),
    .wdata   (wdata_q),
    .mask    (mask),
    .drp_dout(drp_dout),
    .drp_drdy(drp_drdy),
    .busy    (busy),
    .timeout (timeout),
    .drp_den (drp_den),
    .drp_dwe (drp_dwe),
    .drp_din (drp_din),
    .rdata   (rdata)
  );
endmodule

// File: tb/tb_reg_mmcm_drp_multi.sv
// tb_reg_mmcm_drp_multi: directed table plus handshake sequences for reg_mmcm_drp_multi (2 channels, timeout 8)
module tb_reg_mmcm_drp_multi;
  localparam logic [7:0] A_ADDR = 8'd0, A_DATA = 8'd1, A_RST = 8'd2, A_SEL = 8'd3, A_STAT = 8'd4, A_MASK = 8'd5;
`ifdef DRP_RMW_EN
  localparam logic [7:0] MASK_B0 = 8'hFF;
`else
  localparam logic [7:0] MASK_B0 = 8'h00;
`endif
  typedef struct {
    logic w;
    logic s;
    logic [7:0] a;
    logic [6:0] bc;
    logic [7:0] d;
    logic [7:0] exp;
    logic [1:0] rst;
  } vec_t;
  logic clk_usb = 1'b0;
  logic reset_i = 1'b1;
  logic [6:0] drp_addr;
  logic [15:0] drp_din;
  logic drp_dwe;
  logic [1:0] drp_den;
  logic [31:0] drp_dout = '0;
  logic [1:0] drp_drdy = '0;
  logic [1:0] drp_reset;
  int checks = 0, failures = 0, den_cnt = 0, dwe_cnt = 0, den0, dwe0, n;
  logic [7:0] v;
  vec_t tbl[12];
  reg_mmcm_drp_multi_if #(.pBYTECNT_SIZE(7)) bus();
  reg_mmcm_drp_multi #(.pBYTECNT_SIZE(7), .pCHANNELS(2), .pTIMEOUT(8)) dut (
    .clk_usb  (clk_usb),
    .reset_i  (reset_i),
    .bus      (bus),
    .drp_addr (drp_addr),
    .drp_din  (drp_din),
    .drp_dwe  (drp_dwe),
    .drp_den  (drp_den),
    .drp_dout (drp_dout),
    .drp_drdy (drp_drdy),
    .drp_reset(drp_reset)
  );
  always #5 clk_usb = ~clk_usb;
  always @(negedge clk_usb) begin
    den_cnt += $countones(drp_den);
    dwe_cnt += int'(drp_dwe);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    @(negedge clk_usb);
    bus.selected = 1'b1;
    bus.reg_address = a;
    bus.reg_bytecnt = bc;
    bus.reg_datai = d;
    bus.reg_write = 1'b1;
    @(negedge clk_usb);
    bus.reg_write = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [6:0] bc, input logic s, output logic [7:0] r);
    bus.selected = s;
    bus.reg_address = a;
    bus.reg_bytecnt = bc;
    bus.reg_read = 1'b1;
    #1 r = bus.reg_datao;
    bus.reg_read = 1'b0;
    bus.selected = 1'b1;
  endtask
  task automatic rchk(input string nm, input logic [7:0] a, input logic [6:0] bc, input logic [7:0] exp);
    logic [7:0] r;
    rd(a, bc, 1'b1, r);
    chk(nm, r, exp);
  endtask
  task automatic mark();
    #1 den0 = den_cnt;
    dwe0 = dwe_cnt;
  endtask
  initial begin
    #100000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.selected = 1'b0;
    bus.reg_address = '0;
    bus.reg_bytecnt = '0;
    bus.reg_datai = '0;
    bus.reg_read = 1'b0;
    bus.reg_write = 1'b0;
    tbl[0]  = '{1'b0, 1'b1, A_STAT, 7'd0, 8'h00, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, A_ADDR, 7'd0, 8'h00, 8'h00, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, A_DATA, 7'd0, 8'h00, 8'h00, 2'd0};
    tbl[3]  = '{1'b0, 1'b1, A_DATA, 7'd1, 8'h00, 8'h00, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, A_SEL,  7'd0, 8'h01, 8'h01, 2'd0};
    tbl[5]  = '{1'b1, 1'b1, A_RST,  7'd0, 8'h03, 8'h03, 2'd3};
    tbl[6]  = '{1'b0, 1'b0, A_RST,  7'd0, 8'h00, 8'h00, 2'd3};
    tbl[7]  = '{1'b1, 1'b1, A_RST,  7'd0, 8'h02, 8'h02, 2'd2};
    tbl[8]  = '{1'b1, 1'b1, A_SEL,  7'd0, 8'h07, 8'h07, 2'd2};
    tbl[9]  = '{1'b1, 1'b1, A_RST,  7'd0, 8'h00, 8'h00, 2'd0};
    tbl[10] = '{1'b0, 1'b1, A_MASK, 7'd0, 8'h00, MASK_B0, 2'd0};
    tbl[11] = '{1'b1, 1'b1, A_SEL,  7'd0, 8'hF9, 8'h01, 2'd0};
    repeat (2) @(negedge clk_usb);
    chk("reset den", drp_den, 2'b00);
    chk("reset dwe", drp_dwe, 1'b0);
    chk("reset addr", drp_addr, 7'h00);
    chk("reset din", drp_din, 16'h0000);
    chk("reset drp_reset", drp_reset, 2'b00);
    reset_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].bc, tbl[i].d);
      rd(tbl[i].a, tbl[i].bc, tbl[i].s, v);
      chk($sformatf("vec%0d datao", i), v, tbl[i].exp);
      chk($sformatf("vec%0d drp_reset", i), drp_reset, tbl[i].rst);
    end
    // read on channel 1, drdy three cycles after den
    mark();
    wr(A_ADDR, 0, 8'h28);
    chk("rd den", drp_den, 2'b10);
    chk("rd dwe", drp_dwe, 1'b0);
    chk("rd addr", drp_addr, 7'h28);
    rchk("rd busy", A_STAT, 0, 8'h01);
    rchk("rd addr reg", A_ADDR, 0, 8'hA8);
    @(negedge clk_usb);
    drp_drdy = 2'b01;
    drp_dout = 32'h0000_DEAD;
    chk("rd den low", drp_den, 2'b00);
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    rchk("rd other drdy ignored", A_STAT, 0, 8'h01);
    @(negedge clk_usb);
    drp_drdy = 2'b10;
    drp_dout = 32'hBEEF_0000;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    drp_dout = '0;
    rchk("rd status", A_STAT, 0, 8'h00);
    rchk("rd data b0", A_DATA, 0, 8'hEF);
    rchk("rd data b1", A_DATA, 1, 8'hBE);
    chk("rd den pulses", den_cnt - den0, 1);
    chk("rd dwe pulses", dwe_cnt - dwe0, 0);
    // write on channel 0
    wr(A_SEL, 0, 8'h00);
    wr(A_DATA, 0, 8'h34);
    wr(A_DATA, 1, 8'h12);
    mark();
    wr(A_ADDR, 0, 8'h88);
    chk("wr addr", drp_addr, 7'h08);
    chk("wr din", drp_din, 16'h1234);
    chk("wr den", drp_den, 2'b01);
    chk("wr dwe", drp_dwe, 1'b1);
    @(negedge clk_usb);
    chk("wr dwe low", drp_dwe, 1'b0);
    rchk("wr busy", A_STAT, 0, 8'h01);
    @(negedge clk_usb);
    drp_drdy = 2'b01;
    drp_dout = 32'h0000_5555;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    rchk("wr done", A_STAT, 0, 8'h00);
    rchk("wr capture", A_DATA, 0, 8'h55);
    chk("wr den pulses", den_cnt - den0, 1);
    chk("wr dwe pulses", dwe_cnt - dwe0, 1);
    // timeout with no drdy
    wr(A_ADDR, 0, 8'h05);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      rd(A_STAT, 0, 1'b1, v);
      if (!v[0]) break;
      n++;
      @(negedge clk_usb);
    end
    chk("to busy cycles", n, 9);
    rchk("to status", A_STAT, 0, 8'h02);
    rchk("to rdata kept", A_DATA, 0, 8'h55);
    wr(A_STAT, 0, 8'h00);
    rchk("to cleared", A_STAT, 0, 8'h00);
    // overrun during WAIT
    mark();
    wr(A_ADDR, 0, 8'h10);
    wr(A_ADDR, 0, 8'h11);
    chk("ovr addr kept", drp_addr, 7'h10);
    rchk("ovr status", A_STAT, 0, 8'h05);
    wr(A_DATA, 0, 8'hAA);
    drp_drdy = 2'b01;
    drp_dout = 32'h0000_0001;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    rchk("ovr sticky", A_STAT, 0, 8'h04);
    chk("ovr den pulses", den_cnt - den0, 1);
    wr(A_STAT, 0, 8'h00);
    rchk("ovr cleared", A_STAT, 0, 8'h00);
    // bad select
    wr(A_SEL, 0, 8'h05);
    mark();
    wr(A_ADDR, 0, 8'h13);
    chk("bad den", drp_den, 2'b00);
    rchk("bad status", A_STAT, 0, 8'h08);
    chk("bad addr", drp_addr, 7'h13);
    repeat (2) @(negedge clk_usb);
    chk("bad den pulses", den_cnt - den0, 0);
    wr(A_STAT, 0, 8'h00);
    rchk("bad cleared", A_STAT, 0, 8'h00);
    // async reset in the middle of an access
    wr(A_SEL, 0, 8'h01);
    wr(A_RST, 0, 8'h03);
    wr(A_ADDR, 0, 8'h02);
    chk("abort pre den", drp_den, 2'b10);
    #2 reset_i = 1'b1;
    #1 chk("abort den", drp_den, 2'b00);
    chk("abort dwe", drp_dwe, 1'b0);
    chk("abort drp_reset", drp_reset, 2'b00);
    rchk("abort status", A_STAT, 0, 8'h00);
    rchk("abort sel", A_SEL, 0, 8'h00);
    rchk("abort addr", A_ADDR, 0, 8'h00);
    rchk("abort rdata", A_DATA, 0, 8'h00);
    @(negedge clk_usb);
    reset_i = 1'b0;
    mark();
    repeat (3) @(negedge clk_usb);
    chk("abort no den", den_cnt - den0, 0);
    // drdy on the last wait cycle wins over timeout
    wr(A_ADDR, 0, 8'h03);
    repeat (8) @(negedge clk_usb);
    drp_drdy = 2'b01;
    drp_dout = 32'h0000_7777;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    rchk("race status", A_STAT, 0, 8'h00);
    rchk("race data", A_DATA, 0, 8'h77);
`ifdef DRP_RMW_EN
    wr(A_MASK, 0, 8'hF0);
    wr(A_MASK, 1, 8'h00);
    rchk("rmw mask", A_MASK, 0, 8'hF0);
    wr(A_DATA, 0, 8'hA0);
    wr(A_DATA, 1, 8'h00);
    mark();
    wr(A_ADDR, 0, 8'h81);
    chk("rmw rd den", drp_den, 2'b01);
    chk("rmw rd dwe", drp_dwe, 1'b0);
    repeat (2) @(negedge clk_usb);
    drp_drdy = 2'b01;
    drp_dout = 32'h0000_1234;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    chk("rmw wr den", drp_den, 2'b01);
    chk("rmw wr dwe", drp_dwe, 1'b1);
    chk("rmw wr din", drp_din, 16'h12A4);
    repeat (2) @(negedge clk_usb);
    drp_drdy = 2'b01;
    @(negedge clk_usb);
    drp_drdy = 2'b00;
    rchk("rmw done", A_STAT, 0, 8'h00);
    chk("rmw den pulses", den_cnt - den0, 2);
    chk("rmw dwe pulses", dwe_cnt - dwe0, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
